// File: rtl/sig_debouncer_if.sv
// Level-conditioning bundle between a raw input source and sig_debouncer.
// Master drives the raw level and enable; slave returns the filtered level.
interface sig_debouncer_if;
  logic sig_in;
  logic enable;
  logic sig_out;
  logic pending;
  logic glitch;

  modport master (
    output sig_in,
    output enable,
    input  sig_out,
    input  pending,
    input  glitch
  );

  modport slave (
    input  sig_in,
    input  enable,
    output sig_out,
    output pending,
    output glitch
  );
endinterface

// File: rtl/sig_debouncer.sv
// Synchronise, prescale-sample and debounce a raw asynchronous level.
// Output moves only after STABLE_COUNT agreeing samples; aborts pulse glitch.
module sig_debouncer #(
  parameter int SYNC_STAGES  = 2,
  parameter int PRESCALE     = 1,
  parameter int STABLE_COUNT = 4,
  parameter bit RESET_LEVEL  = 1'b0
) (
  input logic             clk,
  input logic             rst_n,
  sig_debouncer_if.slave  bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CW = $clog2(STABLE_COUNT + 1);

  if (SYNC_STAGES < 2 || PRESCALE < 1 || STABLE_COUNT < 1) begin : g_bad
    $error("sig_debouncer: illegal parameter set");
  end

  typedef enum logic {
    IDLE,
    CONFIRM
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [PW-1:0]          pre_q, pre_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  state_e                 state_q, state_d;
  logic                   out_q, out_d;
  logic                   glitch_q, glitch_d;
  logic                   s;
  logic                   tick;

  assign s    = sync_q[SYNC_STAGES-1];
  assign tick = bus.enable && (pre_q == PW'(PRESCALE - 1));

  // The synchroniser ignores enable so s is never stale on resume.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], bus.sig_in};
    pre_d  = pre_q;
    if (bus.enable) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    glitch_d = 1'b0;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (s != out_q) begin
            if (STABLE_COUNT == 1) begin
              out_d = s;
            end else begin
              cnt_d   = CW'(1);
              state_d = CONFIRM;
            end
          end
        end
        CONFIRM: begin
          if (s == out_q) begin
            cnt_d    = '0;
            state_d  = IDLE;
            glitch_d = 1'b1;
          end else if (cnt_q == CW'(STABLE_COUNT - 1)) begin
            out_d   = s;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= {SYNC_STAGES{RESET_LEVEL}};
      pre_q    <= '0;
      cnt_q    <= '0;
      state_q  <= IDLE;
      out_q    <= RESET_LEVEL;
      glitch_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      out_q    <= out_d;
      glitch_q <= glitch_d;
    end
  end

  assign bus.sig_out = out_q;
  assign bus.pending = (state_q == CONFIRM);
  assign bus.glitch  = glitch_q;

endmodule

// File: tb/tb_sig_debouncer.sv
// Directed checks for sig_debouncer: default instance plus a
// prescaled instance (PRESCALE=3) sharing clock and reset.
module tb_sig_debouncer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  sig_debouncer_if bus1 ();
  sig_debouncer_if bus2 ();

  sig_debouncer dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  sig_debouncer #(
    .SYNC_STAGES  (2),
    .PRESCALE     (3),
    .STABLE_COUNT (4),
    .RESET_LEVEL  (1'b0)
  ) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int   n;
    int   r_cnt;
    int   f_cnt;
    int   g_cnt;
    logic prev;
    logic hi;

    bus1.sig_in = 1'b1;
    bus1.enable = 1'b1;
    bus2.sig_in = 1'b0;
    bus2.enable = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out", bus1.sig_out, 0);
    chk("rst_pend", bus1.pending, 0);
    chk("rst_glitch", bus1.glitch, 0);
    repeat (3) step();
    chk("rst_hold_out", bus1.sig_out, 0);
    chk("rst_hold_pend", bus1.pending, 0);

    // rising accept
    rst_n = 1'b1;
    for (int e = 0; e < 8; e++) begin
      step();
      chk($sformatf("rise_pend_e%0d", e), bus1.pending,
          (e >= 2 && e <= 4) ? 8'd1 : 8'd0);
      chk($sformatf("rise_out_e%0d", e), bus1.sig_out,
          (e >= 5) ? 8'd1 : 8'd0);
      chk($sformatf("rise_gl_e%0d", e), bus1.glitch, 0);
    end

    // falling accept through an edge-detector model
    bus1.sig_in = 1'b0;
    prev = 1'b1;
    r_cnt = 0;
    f_cnt = 0;
    for (int e = 0; e < 10; e++) begin
      step();
      chk($sformatf("fall_out_e%0d", e), bus1.sig_out,
          (e < 5) ? 8'd1 : 8'd0);
      if (prev && !bus1.sig_out) f_cnt++;
      if (!prev && bus1.sig_out) r_cnt++;
      prev = bus1.sig_out;
    end
    chk("fall_f_pulses", 8'(f_cnt), 1);
    chk("fall_r_pulses", 8'(r_cnt), 0);

    // two-cycle glitch
    bus1.sig_in = 1'b1;
    for (int e = 0; e < 8; e++) begin
      step();
      if (e == 1) bus1.sig_in = 1'b0;
      chk($sformatf("gl_pend_e%0d", e), bus1.pending,
          (e == 2 || e == 3) ? 8'd1 : 8'd0);
      chk($sformatf("gl_gl_e%0d", e), bus1.glitch,
          (e == 4) ? 8'd1 : 8'd0);
      chk($sformatf("gl_out_e%0d", e), bus1.sig_out, 0);
    end

    // enable freeze mid-confirm
    bus1.sig_in = 1'b1;
    for (int e = 0; e < 16; e++) begin
      step();
      chk($sformatf("frz_pend_e%0d", e), bus1.pending,
          (e >= 2 && e <= 14) ? 8'd1 : 8'd0);
      chk($sformatf("frz_out_e%0d", e), bus1.sig_out,
          (e >= 15) ? 8'd1 : 8'd0);
      chk($sformatf("frz_gl_e%0d", e), bus1.glitch, 0);
      if (e == 3) bus1.enable = 1'b0;
      if (e == 13) bus1.enable = 1'b1;
    end

    // async reset mid-confirm
    bus1.sig_in = 1'b0;
    repeat (3) step();
    chk("ar_pre_pend", bus1.pending, 1);
    chk("ar_pre_out", bus1.sig_out, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_out", bus1.sig_out, 0);
    chk("ar_pend", bus1.pending, 0);
    chk("ar_gl", bus1.glitch, 0);
    step();
    chk("ar_gl_next", bus1.glitch, 0);
    rst_n = 1'b1;
    repeat (4) step();

    // prescaled latency at random phases
    for (int t = 0; t < 20; t++) begin
      repeat ($urandom_range(0, 5)) step();
      bus2.sig_in = 1'b1;
      n = 0;
      while (!bus2.sig_out && n < 40) begin
        step();
        n++;
      end
      chk($sformatf("ps_rise_t%0d_n%0d", t, n), 8'(n >= 12 && n <= 14), 1);
      repeat ($urandom_range(0, 5)) step();
      bus2.sig_in = 1'b0;
      n = 0;
      while (bus2.sig_out && n < 40) begin
        step();
        n++;
      end
      chk($sformatf("ps_fall_t%0d_n%0d", t, n), 8'(n >= 12 && n <= 14), 1);
    end

    // one-tick pulse on the prescaled instance
    repeat (6) step();
    g_cnt = 0;
    hi = 1'b0;
    bus2.sig_in = 1'b1;
    for (int e = 0; e < 27; e++) begin
      step();
      if (e == 2) bus2.sig_in = 1'b0;
      if (bus2.glitch) g_cnt++;
      if (bus2.sig_out) hi = 1'b1;
    end
    chk("ps_pulse_glitches", 8'(g_cnt), 1);
    chk("ps_pulse_out", hi, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
